// File: rtl/celera_brick_pkg.sv
// Shared definitions for the registered logic-library bricks: FSM state
// encoding plus small elaboration-time helpers for counter sizing and
// parameter legality.
package celera_brick_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } dbr_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Count-style parameters must be at least one.
    function automatic bit param_legal(input int n);
        return (n >= 1);
    endfunction

endpackage

// File: rtl/celsync2.sv
// Two-flop synchroniser bringing an asynchronous level into the CELCLK
// domain. Both flops reset to RST_VAL. Supply pins are carried for the
// cell netlist only.
module celsync2 #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic CELCLK,
    input  logic CELRSTN,
    input  logic CELV,
    input  logic CELG,
    input  logic SUB,
    input  logic d,
    output logic q
);

    logic s1;
    logic unused_pwr;

    // Supply, ground and substrate have no logical function in RTL.
    assign unused_pwr = ^{CELV, CELG, SUB};

    // Shift the raw level through two flops to settle metastability.
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_reg_xloop_xfreq.sv
// Debounce register: synchronises a raw level, qualifies any change over
// PRESCALE*FILT_LEN enabled cycles, then presents a registered level with
// one-cycle rise/fall strobes and a busy flag while qualifying.
module debounce_reg_xloop_xfreq
    import celera_brick_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int FILT_LEN = 3,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic CELCLK,
    input  logic CELRSTN,
    input  logic CELV,
    input  logic CELG,
    input  logic SUB,
    input  logic i,
    input  logic en,
    output logic o,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int PW = cnt_width(PRESCALE);
    localparam int FW = cnt_width(FILT_LEN);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILT_LEN - 1);

    if (!param_legal(PRESCALE)) begin : g_bad_prescale
        $error("debounce_reg_xloop_xfreq: PRESCALE must be 1 or more");
    end
    if (!param_legal(FILT_LEN)) begin : g_bad_filt_len
        $error("debounce_reg_xloop_xfreq: FILT_LEN must be 1 or more");
    end

    logic          s2;
    dbr_state_t    state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          o_n, rise_n, fall_n;

    celsync2 #(
        .RST_VAL (RST_VAL)
    ) u_sync (
        .CELCLK  (CELCLK),
        .CELRSTN (CELRSTN),
        .CELV    (CELV),
        .CELG    (CELG),
        .SUB     (SUB),
        .d       (i),
        .q       (s2)
    );

    // Next-state, counter and output decisions; a change is committed only
    // after FILT_LEN prescaled ticks in which s2 kept differing from o.
    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        fcnt_n  = fcnt;
        o_n     = o;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            IDLE: begin
                pcnt_n = '0;
                fcnt_n = '0;
                if (s2 != o) begin
                    state_n = QUAL;
                end
            end
            QUAL: begin
                if (s2 == o) begin
                    // Input returned to the current level: drop the attempt.
                    state_n = IDLE;
                    pcnt_n  = '0;
                    fcnt_n  = '0;
                end else if (en) begin
                    if (pcnt != P_LAST) begin
                        pcnt_n = pcnt + 1'b1;
                    end else begin
                        pcnt_n = '0;
                        if (fcnt == F_LAST) begin
                            o_n     = s2;
                            rise_n  = s2;
                            fall_n  = ~s2;
                            fcnt_n  = '0;
                            state_n = IDLE;
                        end else begin
                            fcnt_n = fcnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                pcnt_n  = '0;
                fcnt_n  = '0;
            end
        endcase
    end

    // Register FSM, counters and every output; reset discards any
    // in-flight qualification without a strobe.
    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            state <= IDLE;
            pcnt  <= '0;
            fcnt  <= '0;
            o     <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
            fcnt  <= fcnt_n;
            o     <= o_n;
            rise  <= rise_n;
            fall  <= fall_n;
            busy  <= (state_n == QUAL);
        end
    end

endmodule

// File: tb/tb_debounce_reg_xloop_xfreq.sv
// Bench for debounce_reg_xloop_xfreq: three configurations driven from
// shared stimulus, each checked every cycle against a counting model.
module tb_debounce_reg_xloop_xfreq;

    localparam int N = 3;

    function automatic int ps(input int n);
        case (n)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int fl(input int n);
        case (n)
            0:       return 3;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic rv(input int n);
        return (n == 2) ? 1'b1 : 1'b0;
    endfunction

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic celv = 1'b1;
    logic celg = 1'b0;
    logic sub = 1'b0;
    logic i = 1'b0;
    logic en = 1'b1;
    logic [N-1:0] o_w, rise_w, fall_w, busy_w;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    int rise0_cnt = 0;

    always #5 clk = ~clk;

    debounce_reg_xloop_xfreq #(.PRESCALE(4), .FILT_LEN(3), .RST_VAL(1'b0)) dut0 (
        .CELCLK(clk), .CELRSTN(rstn), .CELV(celv), .CELG(celg), .SUB(sub),
        .i(i), .en(en), .o(o_w[0]), .rise(rise_w[0]), .fall(fall_w[0]), .busy(busy_w[0]));

    debounce_reg_xloop_xfreq #(.PRESCALE(1), .FILT_LEN(1), .RST_VAL(1'b0)) dut1 (
        .CELCLK(clk), .CELRSTN(rstn), .CELV(celv), .CELG(celg), .SUB(sub),
        .i(i), .en(en), .o(o_w[1]), .rise(rise_w[1]), .fall(fall_w[1]), .busy(busy_w[1]));

    debounce_reg_xloop_xfreq #(.PRESCALE(3), .FILT_LEN(2), .RST_VAL(1'b1)) dut2 (
        .CELCLK(clk), .CELRSTN(rstn), .CELV(celv), .CELG(celg), .SUB(sub),
        .i(i), .en(en), .o(o_w[2]), .rise(rise_w[2]), .fall(fall_w[2]), .busy(busy_w[2]));

    // Model state: synchroniser taps, committed level, and a single count of
    // enabled cycles spent qualifying the current difference.
    logic ms1 [N];
    logic ms2 [N];
    logic mo  [N];
    logic mr  [N];
    logic mf  [N];
    logic mb  [N];
    bit   act [N];
    int   cnt [N];

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    task automatic wait_after(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Reference model advanced on every rising edge from pre-edge inputs.
    always @(posedge clk) begin
        cyc++;
        for (int n = 0; n < N; n++) begin
            if (!rstn) begin
                ms1[n] = rv(n);
                ms2[n] = rv(n);
                mo[n]  = rv(n);
                mr[n]  = 1'b0;
                mf[n]  = 1'b0;
                mb[n]  = 1'b0;
                act[n] = 1'b0;
                cnt[n] = 0;
            end else begin
                mr[n] = 1'b0;
                mf[n] = 1'b0;
                if (!act[n]) begin
                    if (ms2[n] != mo[n]) begin
                        act[n] = 1'b1;
                        cnt[n] = 0;
                    end
                end else if (ms2[n] == mo[n]) begin
                    act[n] = 1'b0;
                end else if (en) begin
                    cnt[n]++;
                    if (cnt[n] == ps(n) * fl(n)) begin
                        mo[n]  = ms2[n];
                        mr[n]  = ms2[n];
                        mf[n]  = ~ms2[n];
                        act[n] = 1'b0;
                    end
                end
                mb[n]  = act[n];
                ms2[n] = ms1[n];
                ms1[n] = i;
            end
        end
        if (!rstn) chk_on = 1'b1;
    end

    // Compare every output of every instance against the model each cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int n = 0; n < N; n++) begin
                chk($sformatf("o[%0d]", n),    32'(o_w[n]),    32'(mo[n]));
                chk($sformatf("rise[%0d]", n), 32'(rise_w[n]), 32'(mr[n]));
                chk($sformatf("fall[%0d]", n), 32'(fall_w[n]), 32'(mf[n]));
                chk($sformatf("busy[%0d]", n), 32'(busy_w[n]), 32'(mb[n]));
                chk($sformatf("excl[%0d]", n), 32'(rise_w[n] & fall_w[n]), 32'(0));
            end
            if (rise_w[0] === 1'b1) rise0_cnt++;
        end
    end

    initial begin
        int k;
        int r0;
        int run;

        // Reset values
        wait_after(3);
        chk("rst_o0", 32'(o_w[0]), 32'(0));
        chk("rst_busy0", 32'(busy_w[0]), 32'(0));
        chk("rst_rise0", 32'(rise_w[0]), 32'(0));
        chk("rst_o2", 32'(o_w[2]), 32'(1));
        chk("rst_fall2", 32'(fall_w[2]), 32'(0));
        rstn = 1'b1;

        // RST_VAL=1 instance sees i=0 from edge 4: fall at 4+2+6 = 12
        wait_after(5);
        chk("rv1_busy_pre", 32'(busy_w[2]), 32'(0));
        wait_after(6);
        chk("rv1_busy", 32'(busy_w[2]), 32'(1));
        wait_after(11);
        chk("rv1_o_hold", 32'(o_w[2]), 32'(1));
        wait_after(12);
        chk("rv1_o", 32'(o_w[2]), 32'(0));
        chk("rv1_fall", 32'(fall_w[2]), 32'(1));

        // Main rise: sampled at edge k
        wait_after(14);
        i = 1'b1;
        k = cyc + 1;
        wait_after(k + 1);
        chk("s1_busy_pre", 32'(busy_w[0]), 32'(0));
        wait_after(k + 2);
        chk("s1_busy", 32'(busy_w[0]), 32'(1));
        chk("p1_o_pre", 32'(o_w[1]), 32'(0));
        wait_after(k + 3);
        chk("p1_o", 32'(o_w[1]), 32'(1));
        chk("p1_rise", 32'(rise_w[1]), 32'(1));
        wait_after(k + 13);
        chk("s1_o_pre", 32'(o_w[0]), 32'(0));
        wait_after(k + 14);
        chk("s1_o", 32'(o_w[0]), 32'(1));
        chk("s1_rise", 32'(rise_w[0]), 32'(1));
        wait_after(k + 15);
        chk("s1_rise_end", 32'(rise_w[0]), 32'(0));
        chk("s1_busy_end", 32'(busy_w[0]), 32'(0));

        // Settle low, then a 5-cycle high glitch
        i = 1'b0;
        wait_after(cyc + 40);
        chk("gl_o_start", 32'(o_w[0]), 32'(0));
        r0 = rise0_cnt;
        i = 1'b1;
        k = cyc + 1;
        wait_after(k + 2);
        chk("gl_busy", 32'(busy_w[0]), 32'(1));
        wait_after(k + 4);
        i = 1'b0;
        wait_after(k + 30);
        chk("gl_o", 32'(o_w[0]), 32'(0));
        chk("gl_norise", 32'(rise0_cnt - r0), 32'(0));

        // Settle high, then a fall with en low on edges k+5..k+10
        i = 1'b1;
        wait_after(cyc + 40);
        i = 1'b0;
        k = cyc + 1;
        wait_after(k + 4);
        en = 1'b0;
        wait_after(k + 10);
        en = 1'b1;
        wait_after(k + 19);
        chk("en_o_hold", 32'(o_w[0]), 32'(1));
        wait_after(k + 20);
        chk("en_o", 32'(o_w[0]), 32'(0));
        chk("en_fall", 32'(fall_w[0]), 32'(1));
        wait_after(k + 21);
        chk("en_fall_end", 32'(fall_w[0]), 32'(0));

        // Reset on the edge before the commit edge
        wait_after(cyc + 40);
        i = 1'b1;
        k = cyc + 1;
        wait_after(k + 12);
        rstn = 1'b0;
        wait_after(k + 13);
        chk("mr_o", 32'(o_w[0]), 32'(0));
        chk("mr_busy", 32'(busy_w[0]), 32'(0));
        chk("mr_rise", 32'(rise_w[0]), 32'(0));
        rstn = 1'b1;
        wait_after(k + 14);
        chk("mr_o_after", 32'(o_w[0]), 32'(0));
        chk("mr_rise_after", 32'(rise_w[0]), 32'(0));
        chk("mr_busy_after", 32'(busy_w[0]), 32'(0));

        // Regular toggling every 10 cycles
        for (int t = 0; t < 30; t++) begin
            i = ~i;
            wait_after(cyc + 10);
        end

        // Randomised levels, run lengths, enable gaps and occasional resets
        run = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (run == 0) begin
                i = ~i;
                run = $urandom_range(1, 30);
            end
            run--;
            en   = ($urandom_range(0, 9) != 0);
            rstn = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rstn = 1'b1;
        en = 1'b1;
        wait_after(cyc + 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
